// File: rtl/dm_port_arbiter_if.sv
// Request/response bundle between one DM requester and the arbiter.
// master = requester side, slave = arbiter side.
interface dm_port_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter serialising CPU and debug accesses to the
// single-port data memory, one access and one response at a time.
module dm_port_arbiter #(
  parameter int AW     = 5,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          RN,
  dm_port_arbiter_if.slave cpu,
  dm_port_arbiter_if.slave dbg,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_t        state_q, state_d;
  logic          last_q;
  logic          port_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [1:0]    cnt_q;
  logic [DW-1:0] crd_q, drd_q;
  logic          gnt_cpu, gnt_dbg;
  logic          accept;

  // last_q = 1 means dbg was granted last, so cpu wins a tie
  assign gnt_cpu = cpu.req_valid & (~dbg.req_valid | last_q);
  assign gnt_dbg = dbg.req_valid & ~gnt_cpu;
  assign accept  = (state_q == IDLE) & (gnt_cpu | gnt_dbg);

  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign cpu.rsp_rdata = crd_q;
  assign dbg.rsp_rdata = drd_q;

  always_comb begin
    state_d       = state_q;
    cpu.req_ready = 1'b0;
    dbg.req_ready = 1'b0;
    cpu.rsp_valid = 1'b0;
    dbg.rsp_valid = 1'b0;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    unique case (state_q)
      IDLE: begin
        cpu.req_ready = gnt_cpu;
        dbg.req_ready = gnt_dbg;
        if (accept) state_d = ISSUE;
      end
      ISSUE: begin
        mem_en  = 1'b1;
        mem_we  = we_q;
        state_d = we_q ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt_q == 2'd0) state_d = RESP;
      end
      RESP: begin
        cpu.rsp_valid = ~port_q;
        dbg.rsp_valid = port_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RN) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= 2'd0;
      crd_q   <= '0;
      drd_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        port_q  <= gnt_dbg;
        last_q  <= gnt_dbg;
        we_q    <= gnt_dbg ? dbg.req_we : cpu.req_we;
        addr_q  <= gnt_dbg ? dbg.req_addr : cpu.req_addr;
        wdata_q <= gnt_dbg ? dbg.req_wdata : cpu.req_wdata;
      end
      if (state_q == ISSUE) begin
        cnt_q <= CNT_INIT;
        if (we_q && !port_q) crd_q <= '0;
        if (we_q && port_q)  drd_q <= '0;
      end
      // final WAIT cycle is when the DM read data is valid
      if (state_q == WAIT) begin
        if (cnt_q == 2'd0) begin
          if (!port_q) crd_q <= mem_rdata;
          if (port_q)  drd_q <= mem_rdata;
        end else begin
          cnt_q <= cnt_q - 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Randomized bench: four arbiters (RD_LAT 1..4) each checked
// cycle by cycle against a transaction-level model.
module tb_dm_port_arbiter;

  localparam int NCYC = 600;

  logic clk;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] done = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, want);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : lane
    localparam int L = g + 1;

    dm_port_arbiter_if #(.AW(5), .DW(32)) cpu_if ();
    dm_port_arbiter_if #(.AW(5), .DW(32)) dbg_if ();

    logic        rn;
    logic        mem_en, mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [31:0] dm [32];
    logic [31:0] pipe [4];

    dm_port_arbiter #(.AW(5), .DW(32), .RD_LAT(L)) dut (
      .clk       (clk),
      .RN        (rn),
      .cpu       (cpu_if.slave),
      .dbg       (dbg_if.slave),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
    );

    // DM array: read data valid L cycles after the strobe, junk otherwise
    assign mem_rdata = pipe[L-1];

    initial for (int i = 0; i < 32; i++) dm[i] = '0;

    always @(posedge clk) begin
      if (mem_en && mem_we) dm[mem_addr] <= mem_wdata;
      pipe[0] <= (mem_en && !mem_we) ? dm[mem_addr] : $urandom;
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end

    logic [31:0] ref_mem [32];
    bit          busy, last, f_port, f_we;
    int          t_acc, t_rsp;
    logic [31:0] f_rd;
    logic [4:0]  e_addr;
    logic [31:0] e_wdata, e_crd, e_drd;
    bit          acc_c, acc_d;
    int          step;

    task automatic new_req(output logic v, output logic we,
                           output logic [4:0] a, output logic [31:0] d);
      v  = ($urandom_range(0, 9) < 6);
      we = ($urandom_range(0, 2) == 0);
      a  = 5'($urandom_range(0, 7));
      d  = $urandom;
    endtask

    initial begin
      for (int i = 0; i < 32; i++) ref_mem[i] = '0;
      busy = 0; last = 1; e_addr = '0; e_wdata = '0;
      e_crd = '0; e_drd = '0; acc_c = 0; acc_d = 0; step = 0;
      t_acc = -10; t_rsp = -10; f_port = 0; f_we = 0; f_rd = '0;
      rn = 1'b1;
      cpu_if.req_valid = 0; cpu_if.req_we = 0;
      cpu_if.req_addr = '0; cpu_if.req_wdata = '0;
      dbg_if.req_valid = 0; dbg_if.req_we = 0;
      dbg_if.req_addr = '0; dbg_if.req_wdata = '0;

      for (int c = 0; c < NCYC; c++) begin
        @(posedge clk);
        #1;
        rn = (c < 2);
        if (c < 16) begin
          // held tie: reads to 1 (cpu) and 2 (dbg)
          cpu_if.req_valid = 1; cpu_if.req_we = 0; cpu_if.req_addr = 5'd1;
          dbg_if.req_valid = 1; dbg_if.req_we = 0; dbg_if.req_addr = 5'd2;
        end else if (step < 2) begin
          if (acc_c && c > 16) step++;
          dbg_if.req_valid = 0;
          cpu_if.req_valid = (step < 2);
          cpu_if.req_we    = (step == 0);
          cpu_if.req_addr  = 5'd5;
          cpu_if.req_wdata = 32'hDEADBEEF;
        end else begin
          rn = ($urandom_range(0, 49) == 0);
          if (acc_c || !cpu_if.req_valid)
            new_req(cpu_if.req_valid, cpu_if.req_we,
                    cpu_if.req_addr, cpu_if.req_wdata);
          else if ($urandom_range(0, 19) == 0)
            cpu_if.req_valid = 0;
          if (acc_d || !dbg_if.req_valid)
            new_req(dbg_if.req_valid, dbg_if.req_we,
                    dbg_if.req_addr, dbg_if.req_wdata);
          else if ($urandom_range(0, 19) == 0)
            dbg_if.req_valid = 0;
        end

        @(negedge clk);
        begin
          bit e_en, ecv, edv, idle, gc, gd;
          string p;
          p = $sformatf("L%0d c%0d ", L, c);
          e_en = busy && (c == t_acc + 1);
          ecv  = busy && (c == t_rsp) && !f_port;
          edv  = busy && (c == t_rsp) && f_port;
          if (ecv) e_crd = f_rd;
          if (edv) e_drd = f_rd;
          idle = !busy;
          gc = idle && cpu_if.req_valid && (!dbg_if.req_valid || last);
          gd = idle && dbg_if.req_valid && !gc;
          if (c > 0) begin
            chk({p, "mem_en"},    32'(mem_en), 32'(e_en));
            chk({p, "mem_we"},    32'(mem_we), 32'(e_en && f_we));
            chk({p, "mem_addr"},  32'(mem_addr), 32'(e_addr));
            chk({p, "mem_wdata"}, mem_wdata, e_wdata);
            chk({p, "cpu_rsp_valid"}, 32'(cpu_if.rsp_valid), 32'(ecv));
            chk({p, "dbg_rsp_valid"}, 32'(dbg_if.rsp_valid), 32'(edv));
            chk({p, "cpu_rsp_rdata"}, cpu_if.rsp_rdata, e_crd);
            chk({p, "dbg_rsp_rdata"}, dbg_if.rsp_rdata, e_drd);
            chk({p, "cpu_req_ready"}, 32'(cpu_if.req_ready), 32'(gc));
            chk({p, "dbg_req_ready"}, 32'(dbg_if.req_ready), 32'(gd));
          end
          if (rn) begin
            busy = 0; last = 1; e_addr = '0; e_wdata = '0;
            e_crd = '0; e_drd = '0; acc_c = 0; acc_d = 0;
          end else begin
            acc_c = gc;
            acc_d = gd;
            if (busy && c == t_rsp) busy = 0;
            if (gc || gd) begin
              busy   = 1;
              t_acc  = c;
              f_port = gd;
              last   = gd;
              f_we   = gd ? dbg_if.req_we : cpu_if.req_we;
              e_addr = gd ? dbg_if.req_addr : cpu_if.req_addr;
              e_wdata = gd ? dbg_if.req_wdata : cpu_if.req_wdata;
              t_rsp  = f_we ? c + 2 : c + L + 2;
              f_rd   = f_we ? 32'h0 : ref_mem[e_addr];
              if (f_we) ref_mem[e_addr] = e_wdata;
            end
          end
        end
      end
      done[g] = 1'b1;
    end
  end

  initial begin
    repeat (NCYC + 5) @(posedge clk);
    chk("lanes_done", 32'(done), 32'hF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
